// File: rtl/cash_key_conditioner.sv
// Cash key front end: synchronise and debounce six denomination keys, turn presses
// into single coin events, queue one per channel and present them on valid/ready.
module cash_key_conditioner #(
  parameter int N_CH     = 6,
  parameter int DB_LIMIT = 1_000_000,
  parameter int DB_W     = 20
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] cash_raw,
  input  logic            accept_en,
  input  logic            coin_ready,
  input  logic            ovf_clr,
  output logic            coin_valid,
  output logic [2:0]      coin_code,
  output logic [6:0]      coin_value,
  output logic [N_CH-1:0] cash_level,
  output logic [N_CH-1:0] pending,
  output logic            ovf
);

  localparam logic [DB_W-1:0] CNT_MAX = DB_W'(DB_LIMIT - 1);

  logic [N_CH-1:0] s1;
  logic [N_CH-1:0] s2;
  logic [N_CH-1:0] level_d;
  logic [DB_W-1:0] cnt [N_CH];

  logic [N_CH-1:0] press;
  logic [N_CH-1:0] new_ev;
  logic [N_CH-1:0] clr_mask;
  logic [N_CH-1:0] pending_nxt;
  logic [2:0]      sel;
  logic            found;
  logic            load;
  logic            drop;

  function automatic logic [6:0] value_of(input logic [2:0] code);
    case (code)
      3'd0:    value_of = 7'd1;
      3'd1:    value_of = 7'd5;
      3'd2:    value_of = 7'd10;
      3'd3:    value_of = 7'd20;
      3'd4:    value_of = 7'd50;
      3'd5:    value_of = 7'd100;
      default: value_of = 7'd0;
    endcase
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      level_d    <= '0;
      cash_level <= '0;
      for (int unsigned i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      s1      <= cash_raw;
      s2      <= s1;
      level_d <= cash_level;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (s2[i] == cash_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          cnt[i]        <= '0;
          cash_level[i] <= ~cash_level[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // A press is the cycle after cash_level rose; level_d holds the prior level.
  assign press  = cash_level & ~level_d;
  assign new_ev = press & {N_CH{accept_en}};

  always_comb begin
    sel   = '0;
    found = 1'b0;
    for (int unsigned i = 0; i < N_CH; i++) begin
      if (pending[i] && !found) begin
        sel   = 3'(i);
        found = 1'b1;
      end
    end
  end

  assign load        = (!coin_valid || coin_ready) && (|pending);
  assign clr_mask    = load ? (N_CH'(1) << sel) : '0;
  assign drop        = |(new_ev & pending & ~clr_mask);
  assign pending_nxt = (pending & ~clr_mask) | new_ev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending    <= '0;
      ovf        <= 1'b0;
      coin_valid <= 1'b0;
      coin_code  <= '0;
      coin_value <= '0;
    end else begin
      pending <= pending_nxt;
      if (drop)         ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      if (load) begin
        coin_valid <= 1'b1;
        coin_code  <= sel;
        coin_value <= value_of(sel);
      end else if (coin_ready) begin
        coin_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cash_key_conditioner.sv
// Randomised bench for cash_key_conditioner: a reference model predicts levels,
// queue and events; a monitor compares the DUT against it every cycle.
module tb_cash_key_conditioner;

  localparam int DB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [5:0] raw;
  logic       acc;
  logic       rdy;
  logic       clr;
  logic       coin_valid;
  logic [2:0] coin_code;
  logic [6:0] coin_value;
  logic [5:0] cash_level;
  logic [5:0] pending;
  logic       ovf;

  cash_key_conditioner #(.N_CH(6), .DB_LIMIT(DB), .DB_W(4)) dut (
    .clk(clk), .rst(rst), .cash_raw(raw), .accept_en(acc), .coin_ready(rdy),
    .ovf_clr(clr), .coin_valid(coin_valid), .coin_code(coin_code),
    .coin_value(coin_value), .cash_level(cash_level), .pending(pending), .ovf(ovf)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int VAL [6] = '{1, 5, 10, 20, 50, 100};

  // Reference model state: raw sample history (bit 0 newest), accepted levels,
  // the queued-event set, the presented slot and the expected event order.
  logic [DB+1:0] m_hist [6];
  logic [5:0]    m_level, m_rose, m_pend;
  logic          m_valid, m_ovf;
  int            exp_q [$];

  task automatic check(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 6; i++) m_hist[i] = '0;
    m_level = '0; m_rose = '0; m_pend = '0;
    m_valid = 1'b0; m_ovf = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit         ld;
    int         s;
    logic [5:0] taken, ev;
    logic       nl;
    ld = (!m_valid || rdy) && (m_pend != 0);
    s = 0;
    for (int i = 5; i >= 0; i--) if (m_pend[i]) s = i;
    taken = ld ? 6'(1 << s) : 6'd0;
    ev = m_rose & {6{acc}};
    if ((ev & m_pend & ~taken) != 0) m_ovf = 1'b1;
    else if (clr)                    m_ovf = 1'b0;
    m_pend = (m_pend & ~taken) | ev;
    if (ld) begin
      m_valid = 1'b1;
      exp_q.push_back(s);
    end else if (rdy) begin
      m_valid = 1'b0;
    end
    // A level flips once the last DB synchronised samples all disagree with it.
    for (int c = 0; c < 6; c++) begin
      m_hist[c] = {m_hist[c][DB:0], raw[c]};
      nl = (m_hist[c][DB+1:2] == {DB{~m_level[c]}}) ? ~m_level[c] : m_level[c];
      m_rose[c]  = nl & ~m_level[c];
      m_level[c] = nl;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) model_reset();
    else     model_step();
    #2;
  endtask

  task automatic hold(input int n);
    repeat (n) tick();
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, "_valid"},   coin_valid, 0);
    check({tag, "_code"},    coin_code,  0);
    check({tag, "_value"},   coin_value, 0);
    check({tag, "_level"},   cash_level, 0);
    check({tag, "_pending"}, pending,    0);
    check({tag, "_ovf"},     ovf,        0);
  endtask

  // Monitor: per-cycle state compare plus event scoreboard.
  initial begin
    bit pv, pr;
    int cur;
    pv = 0; pr = 0; cur = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pv = 0; pr = 0;
      end else begin
        check("coin_valid", coin_valid, m_valid);
        check("cash_level", cash_level, m_level);
        check("pending",    pending,    m_pend);
        check("ovf",        ovf,        m_ovf);
        if (coin_valid && (!pv || pr)) begin
          n_cmp++;
          if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL event_order: got code %0d expected no event at %0t", coin_code, $time);
          end else begin
            cur = exp_q.pop_front();
          end
        end
        if (coin_valid) begin
          check("coin_code",  coin_code,  cur);
          check("coin_value", coin_value, VAL[cur]);
        end
        pv = coin_valid;
        pr = rdy;
      end
    end
  end

  initial begin
    int cd [6];
    rst = 1'b0; raw = '0; acc = 1'b1; rdy = 1'b1; clr = 1'b0;
    model_reset();
    #1 rst = 1'b1;
    #1 check_zero_outputs("reset");
    hold(3);
    rst = 1'b0;
    hold(4);

    // ch2 clean press, then release
    raw = 6'b000100; hold(20);
    raw = '0;        hold(15);

    // ch0 bounce, then stable; then a 3-cycle pulse
    raw = 6'b000001; hold(1);
    raw = '0;        hold(1);
    raw = 6'b000001; hold(1);
    raw = '0;        hold(1);
    raw = 6'b000001; hold(14);
    raw = '0;        hold(10);
    raw = 6'b000001; hold(3);
    raw = '0;        hold(12);

    // ch5 and ch1 together with downstream stalled
    rdy = 1'b0;
    raw = 6'b100010; hold(10);
    hold(10);
    rdy = 1'b1;      hold(4);
    raw = '0;        hold(10);

    // ch3 three presses while stalled, then clear overflow
    rdy = 1'b0;
    repeat (3) begin
      raw = 6'b001000; hold(6);
      raw = '0;        hold(6);
    end
    hold(10);
    clr = 1'b1; hold(1);
    clr = 1'b0; rdy = 1'b1; hold(8);

    // ch4 with presses disabled, then enabled
    acc = 1'b0;
    raw = 6'b010000; hold(10);
    raw = '0;        hold(10);
    acc = 1'b1;
    raw = 6'b010000; hold(10);
    raw = '0;        hold(10);

    // reset while an event is presented and two more are pending
    rdy = 1'b0;
    raw = 6'b000111; hold(12);
    rst = 1'b1;
    #1 check_zero_outputs("async_reset");
    hold(2);
    rst = 1'b0; rdy = 1'b1;
    hold(15);
    raw = '0; hold(10);

    // randomised key activity, handshake and enable
    for (int c = 0; c < 6; c++) cd[c] = $urandom_range(1, 12);
    for (int t = 0; t < 3000; t++) begin
      for (int c = 0; c < 6; c++) begin
        cd[c]--;
        if (cd[c] <= 0) begin
          raw[c] = ~raw[c];
          cd[c] = $urandom_range(1, 12);
        end
      end
      rdy = ($urandom_range(0, 3) != 0);
      acc = ($urandom_range(0, 15) != 0);
      clr = ($urandom_range(0, 31) == 0);
      tick();
    end

    raw = '0; rdy = 1'b1; acc = 1'b1; clr = 1'b0;
    hold(40);
    check("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
